// File: rtl/mac_frame_accum.sv
// mac_frame_accum
// ---------------------------------------------------------------------------
// Accumulates fixed-length frames of LEN signed MAC results. Each frame sum
// is rounded, arithmetically shifted right by SHIFT and saturated to OW bits,
// then presented on a valid/ready output register. The input never stalls.
// A result that arrives while the output register still holds an unaccepted
// result is discarded, and the sticky drop_err flag is raised.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous frame abort; also clears drop_err
//   in_valid   in_data carries a term this cycle
//   in_data    signed IW-bit term
//   out_ready  consumer accepts out_data
//   out_valid  out_data holds an undelivered result
//   out_data   signed OW-bit rounded/saturated frame result
//   out_sat    saturation occurred on out_data
//   busy       partial frame in progress
//   drop_err   sticky: a frame result was discarded
// ---------------------------------------------------------------------------
module mac_frame_accum #(
    parameter int IW    = 38,
    parameter int ACCW  = 48,
    parameter int LEN   = 8,
    parameter int SHIFT = 20,
    parameter int OW    = 16,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic signed [IW-1:0] in_data,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sat,
    output logic                 busy,
    output logic                 drop_err
);

    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    // Rounding constant 2^(SHIFT-1), or zero when truncating.
    localparam logic signed [ACCW:0] RND =
        (ROUND != 0) ? ({{ACCW{1'b0}}, 1'b1} << (SHIFT - 1)) : '0;

    // Output range limits, expressed at the shifted-sum width.
    localparam logic signed [ACCW:0] S_MAX = {{(ACCW + 2 - OW){1'b0}}, {(OW - 1){1'b1}}};
    localparam logic signed [ACCW:0] S_MIN = ~S_MAX;

    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_eff;
    logic [CW-1:0]          cnt_nxt;
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] term;
    logic signed [ACCW-1:0] sum_nxt;
    logic                   frame_done;

    logic                   r_valid;
    logic signed [ACCW-1:0] r_sum;

    logic signed [ACCW:0]   v;
    logic signed [ACCW:0]   s;
    logic signed [OW-1:0]   sat_data;
    logic                   sat_flag;
    logic                   load;
    logic                   drop;

    // ---------------------------------------------------------------------
    // Accumulator datapath
    // ---------------------------------------------------------------------
    assign term = ACCW'(in_data);   // signed cast sign-extends

    // A clr cycle behaves as if the count were already zero, so a term
    // arriving together with clr becomes the first term of a new frame.
    assign cnt_eff    = clr ? '0 : cnt;
    assign sum_nxt    = (cnt_eff == '0) ? term : acc + term;
    assign frame_done = in_valid && (cnt_eff == CNT_LAST);

    // NOTE: every variable assigned in an always_comb gets a default first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        cnt_nxt = cnt_eff;
        if (in_valid) begin
            cnt_nxt = frame_done ? '0 : cnt_eff + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Round, shift, saturate the pending frame sum
    // ---------------------------------------------------------------------
    assign v = (ACCW + 1)'(r_sum) + RND;
    assign s = v >>> SHIFT;

    always_comb begin
        sat_data = s[OW-1:0];
        sat_flag = 1'b0;
        if (s > S_MAX) begin
            sat_data = S_MAX[OW-1:0];
            sat_flag = 1'b1;
        end else if (s < S_MIN) begin
            sat_data = S_MIN[OW-1:0];
            sat_flag = 1'b1;
        end
    end

    // An abort cycle leaves the output register alone; otherwise a finished
    // result either loads into a free/draining register or is discarded.
    assign load = r_valid && !clr && (!out_valid || out_ready);
    assign drop = r_valid && !clr && out_valid && !out_ready;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            acc       <= '0;
            busy      <= 1'b0;
            r_valid   <= 1'b0;
            r_sum     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            drop_err  <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            busy <= (cnt_nxt != '0);
            if (in_valid) begin
                acc <= sum_nxt;
            end

            r_valid <= frame_done;
            if (frame_done) begin
                r_sum <= sum_nxt;
            end

            if (load) begin
                out_valid <= 1'b1;
                out_data  <= sat_data;
                out_sat   <= sat_flag;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (clr) begin
                drop_err <= 1'b0;
            end else if (drop) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mac_frame_accum.md
# mac_frame_accum

Downstream stage for the pre-adder MAC pipeline. It takes the signed MAC result stream (`pout`-width words, one per valid cycle) and accumulates fixed-length frames of LEN terms. It then rounds, shifts and saturates each frame sum to the output width, and presents it on a valid/ready output register. The upstream MAC has no backpressure, so this block never stalls its input. A result that cannot be delivered is dropped and flagged.

## Interface
- IW, 38: input word width; matches the MAC output width (AW+1+BW+1 for 18x18).
- ACCW, 48: accumulator width. Must satisfy ACCW ≥ IW + clog2(LEN), so the accumulator never wraps.
- LEN, 8: terms per frame, ≥1.
- SHIFT, 20: arithmetic right shift applied to the frame sum, ≥1.
- OW, 16: output width, OW ≤ ACCW−SHIFT.
- ROUND, 1: 1 = add 2^(SHIFT−1) before the shift (round half up); 0 = truncate toward −∞.
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous frame abort; also clears `drop_err`.
- in_valid, input, 1: `in_data` carries a term this cycle.
- in_data, input, IW: signed term.
- out_ready, input, 1: consumer accepts `out_data`.
- out_valid, output, 1: `out_data` holds an undelivered result.
- out_data, output, OW: signed rounded/saturated frame result.
- out_sat, output, 1: qualifies `out_data`; saturation occurred.
- busy, output, 1: partial frame in progress (`cnt` ≠ 0).
- drop_err, output, 1: sticky; a frame result was discarded.

## Operation
- State: `cnt` (0..LEN−1), `acc` (ACCW, signed), result stage R (`r_valid`, `r_sum`), output register O.
- Accumulate, on `in_valid`:
  - `cnt`==0: `acc` ← sext(`in_data`).
  - Otherwise: `acc` ← `acc` + sext(`in_data`).
  - `cnt` increments and wraps to 0 after LEN−1.
- Frame complete: on the term with `cnt`==LEN−1, R loads the final sum (`acc`+term, or just the term if LEN=1) and `r_valid`=1 for exactly one cycle.
  - The next frame may start on the very next cycle, with no gaps required.
- Stage R to O:
  - v = `r_sum` + (ROUND ? 2^(SHIFT−1) : 0), computed at ACCW+1 bits.
  - s = v >>> SHIFT.
  - If s > 2^(OW−1)−1: clamp to the maximum and set `out_sat`=1.
  - If s < −2^(OW−1): clamp to the minimum and set `out_sat`=1.
  - Otherwise pass s through with `out_sat`=0.
- Output handshake:
  - O loads when `r_valid` and (!`out_valid` or `out_ready`).
  - If `r_valid` and `out_valid` and !`out_ready`: the new result is discarded, O is unchanged, and `drop_err`←1.
  - `out_valid` clears when `out_ready` is high and no load occurs.
  - `out_data` and `out_sat` are stable while `out_valid` is high and `out_ready` is low.
- clr:
  - Sets `cnt`←0 and `r_valid`←0, and clears `drop_err`.
  - O is untouched; an already-delivered-pending result survives.
  - If `in_valid` is high in the same cycle, that term becomes the first term (`cnt`=0) of a new frame.
- Reset (async, `rst_n`=0): `cnt`, `acc`, R, `out_valid`, `out_data`, `out_sat`, `busy` and `drop_err` all go to 0 immediately. A partial frame is lost.

## Timing
- Last term accepted at edge t: `r_valid` is high after edge t; `out_valid`/`out_data` are updated after edge t+1. Latency is 2 cycles from the last term to the output.
- Sustained throughput is one frame per LEN cycles. With LEN=1 and `out_ready`=1, one output is produced per cycle.
- `busy` is a registered decode of `cnt`≠0.
- `drop_err` rises the cycle after the discard edge.
- There are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: IW=38, ACCW=48, LEN=4, SHIFT=4, OW=8, ROUND=1, `out_ready`=1 unless stated.
- Terms 1,2,3,4 on consecutive cycles → `out_data`=1 (18>>4), `out_sat`=0, valid 2 cycles after the term 4 edge. Then 100×4 → 25.
- Terms 1000×4 → 127 with `out_sat`=1. Terms −1000×4 → −128 with `out_sat`=1.
- Rounding:
  - −8,0,0,0 → 0.
  - −9,0,0,0 → −1.
  - 7,0,0,0 → 0.
  - 8,0,0,0 → 1.
  - With ROUND=0, 15,0,0,0 → 0.
- Backpressure, `out_ready`=0:
  - Frame A (result 25) completes; frame B (16,16,16,16 → 4) completes → `out_valid` holds 25, B is dropped, `drop_err`=1.
  - Raise `out_ready` → 25 is accepted and `out_valid`=0.
  - `clr` → `drop_err`=0.
- Abort:
  - Two terms (50,50), then `clr` with `in_valid` and term 16, then 16,16,16 → output 4; the 50s are excluded.
  - Repeat the prefix with `rst_n` pulsed low mid-frame → all outputs 0 asynchronously, and the next full frame is correct.
- Back-to-back: 5 frames with no idle cycles → 5 outputs spaced 4 cycles apart, `drop_err`=0.
